// File: rtl/prefetch_buffer.sv
// Instruction prefetch buffer: fetches sequential words into a small FIFO,
// one request outstanding, with flush/redirect and in-flight drain.
//
// Parameter: DEPTH - FIFO entries (power of two, 2..16)
// Ports:
//   clk, rst_n          - clock, async active-low reset
//   flush, flush_addr   - redirect request and target address
//   pop                 - consumer takes the head entry
//   mem_req, mem_addr   - instruction memory read request / word address
//   mem_ack, mem_rdata  - memory response for the current request
//   instr_out, pc_out   - head-entry instruction / address (0 when empty)
//   valid_out           - head entry present
//   flush_count         - 16-bit saturating count of flush cycles
//                         (present only when PFB_PERF_CNT_EN is defined)
module prefetch_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic [31:0] flush_addr,
    input  logic        pop,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
`ifdef PFB_PERF_CNT_EN
    output logic [15:0] flush_count,
`endif
    output logic        valid_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DRAIN
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_q, fetch_d;
    logic [31:0]   drain_q, drain_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] cnt_ap;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [31:0]   addr_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic          pop_en;
    logic          push_en;

    assign pop_en  = pop && (count_q != '0) && !flush;
    assign push_en = (state_q == REQ) && mem_ack && !flush;
    // occupancy once this cycle's pop is taken into account
    assign cnt_ap  = count_q - CW'(pop_en);

    always_comb begin
        state_d = state_q;
        fetch_d = fetch_q;
        drain_d = drain_q;
        unique case (state_q)
            IDLE: begin
                if (!flush && (cnt_ap < DEPTH_C))
                    state_d = REQ;
            end
            REQ: begin
                if (flush) begin
                    // in-flight request must still complete; remember its address
                    state_d = mem_ack ? IDLE : DRAIN;
                    drain_d = fetch_q;
                end else if (mem_ack) begin
                    fetch_d = fetch_q + 32'd4;
                    state_d = ((cnt_ap + CW'(1)) < DEPTH_C) ? REQ : IDLE;
                end
            end
            DRAIN: begin
                if (mem_ack)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush)
            fetch_d = {flush_addr[31:2], 2'b00};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            fetch_q <= '0;
            drain_q <= '0;
            count_q <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
        end else begin
            state_q <= state_d;
            fetch_q <= fetch_d;
            drain_q <= drain_d;
            if (flush) begin
                count_q <= '0;
                rd_ptr  <= '0;
                wr_ptr  <= '0;
            end else begin
                count_q <= count_q + CW'(push_en) - CW'(pop_en);
                if (push_en)
                    wr_ptr <= wr_ptr + AW'(1);
                if (pop_en)
                    rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            addr_mem[wr_ptr] <= fetch_q;
            data_mem[wr_ptr] <= mem_rdata;
        end
    end

`ifdef PFB_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            flush_count <= '0;
        else if (flush && (flush_count != 16'hFFFF))
            flush_count <= flush_count + 16'd1;
    end
`endif

    assign mem_req   = (state_q != IDLE);
    assign mem_addr  = (state_q == DRAIN) ? drain_q : fetch_q;
    assign valid_out = (count_q != '0);
    assign instr_out = valid_out ? data_mem[rd_ptr] : '0;
    assign pc_out    = valid_out ? addr_mem[rd_ptr] : '0;

endmodule

// File: doc/prefetch_buffer.md
PREFETCH_BUFFER -- requirements
Module: prefetch_buffer

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entry count (power of two, 2..16).
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 flush  input  1  redirect request (branch taken).
REQ-005 flush_addr  input  32  redirect target address.
REQ-006 pop  input  1  consumer takes head entry (fetch stage not stalled).
REQ-007 mem_req  output  1  instruction memory read request.
REQ-008 mem_addr  output  32  word address of current request.
REQ-009 mem_ack  input  1  memory returns mem_rdata for current request.
REQ-010 mem_rdata  input  32  read data, valid only with mem_ack.
REQ-011 instr_out  output  32  head-entry instruction.
REQ-012 pc_out  output  32  head-entry address.
REQ-013 valid_out  output  1  head entry present.

Function
REQ-014 FIFO of DEPTH entries {addr, instr}; valid_out SHALL equal (count != 0); instr_out/pc_out SHALL show the head entry, and SHALL be 0 when empty.
REQ-015 FSM states IDLE, REQ, DRAIN; mem_req SHALL be high exactly in REQ and DRAIN.
REQ-016 IDLE -> REQ when count (after this cycle's pop) < DEPTH and no flush; mem_addr SHALL be the internal fetch address.
REQ-017 In REQ, mem_req and mem_addr SHALL stay stable until mem_ack; same-cycle ack (combinational memory) SHALL be accepted.
REQ-018 On mem_ack in REQ without flush: push {mem_addr, mem_rdata}, fetch address += 4 modulo 2^32 (0xFFFF_FFFC wraps to 0), go REQ if space remains after push/pop, else IDLE.
REQ-019 At most one request outstanding; request SHALL NOT be issued unless a free entry is reserved for its data.
REQ-020 Push and pop in the same cycle SHALL leave count unchanged; pop while empty SHALL be ignored.
REQ-021 Latency: data accepted on mem_ack cycle SHALL appear on valid_out/instr_out the following cycle (no bypass).
REQ-022 flush SHALL empty the FIFO (valid_out low next cycle) and load fetch address = {flush_addr[31:2], 2'b00}; flush takes priority over pop and push.
REQ-023 flush in REQ without mem_ack -> DRAIN: mem_req/mem_addr held at the old request until mem_ack, returned data discarded, then IDLE.
REQ-024 flush coinciding with mem_ack -> data discarded, next state IDLE, no DRAIN.
REQ-025 flush in DRAIN SHALL update fetch address only; state remains DRAIN.
REQ-026 First request after a flush SHALL use the new fetch address no earlier than the cycle after the FSM reaches IDLE.

Reset
REQ-027 rst_n low SHALL immediately force: state IDLE, count 0, fetch address 0, mem_req 0, valid_out 0, instr_out 0, pc_out 0, mem_addr 0.
REQ-028 Reset mid-transaction SHALL abandon the outstanding request; a late mem_ack after reset release while IDLE SHALL be ignored.
REQ-029 First mem_req SHALL assert the first clock edge after rst_n deasserts, with mem_addr 0x0000_0000.

Configuration
REQ-030 Macro PFB_PERF_CNT_EN defined: extra output flush_count (16-bit) counts accepted flush cycles, saturates at 0xFFFF, resets to 0.
REQ-031 PFB_PERF_CNT_EN undefined: port and counter absent; all other behaviour identical.

Verification
REQ-032 Reset release, mem_ack tied high, pop low -> addresses 0x0,0x4,0x8,0xC fetched, then mem_req low with count 4.
REQ-033 Full FIFO, pop one cycle -> one request to 0x10 issued next cycle; pc_out advances 0x0 -> 0x4.
REQ-034 REQ at 0x8, mem_ack delayed 3 cycles, flush to 0x103 at cycle 1 -> mem_addr holds 0x8 until ack, data dropped, next request 0x100.
REQ-035 flush and mem_ack same cycle -> FIFO empty next cycle, next request at flush target, no DRAIN.
REQ-036 flush_addr 0xFFFF_FFF8, ack always -> fetch 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-037 PFB_PERF_CNT_EN defined, 0x10000 flush cycles -> flush_count reads 0xFFFF.
